mem_port_arbiter: RTL

- Arbitrates one single-port backing memory between the pipeline's instruction-fetch side (I) and its load/store side (D).
- Allows fetch and data memory to share one unified RAM.
- Sequences each access: grant, issue, fixed-latency wait, response capture, ack pulse.
- Sits between the fetch/memory pipeline stages and the RAM; the requester stalls its stage until it receives the ack.

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between the fetch (I) and load/store (D) sides.
// Optional I-side starvation guard: define MEM_PORT_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0]      i_rdata,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0]      d_wdata,
  input  logic [2:0]            d_mode,
  output logic [WIDTH-1:0]      d_rdata,
  output logic                  d_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic [2:0]            mem_mode,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  busy
);

  localparam int         CNT_W     = $clog2(MEM_LATENCY + 1);
  localparam logic [2:0] WORD_MODE = 3'b010;

  if (MEM_LATENCY < 1 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("mem_port_arbiter: MEM_LATENCY and STARVE_LIMIT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OWN_D,
    OWN_I
  } owner_t;

  state_t           state;
  state_t           state_next;
  owner_t           owner;
  logic             we_q;
  logic [CNT_W-1:0] lat_cnt;
  logic             grant;
  logic             grant_i;
  logic             prefer_i;
  logic             capture;

  // D normally wins because it belongs to the older instruction.
  assign grant   = (state == IDLE) && (d_req || i_req);
  assign grant_i = i_req && (!d_req || prefer_i);
  assign capture = (state == WAIT) && (lat_cnt == CNT_W'(1));

`ifdef MEM_PORT_ARB_FAIRNESS_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt;

  assign prefer_i = (starve_cnt == STARVE_W'(STARVE_LIMIT));

  // Counts D grants that overtook a waiting fetch; any other grant resets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (grant_i || !i_req) begin
        starve_cnt <= '0;
      end else if (!prefer_i) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end
`else
  assign prefer_i = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (d_req || i_req) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (lat_cnt == CNT_W'(1)) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_D;
      we_q      <= 1'b0;
      lat_cnt   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_mode  <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state <= state_next;

      // Request fields are latched here, so later changes on the inputs are ignored.
      if (grant) begin
        owner    <= grant_i ? OWN_I : OWN_D;
        we_q     <= !grant_i && d_we;
        mem_addr <= grant_i ? i_addr : d_addr;
        mem_mode <= grant_i ? WORD_MODE : d_mode;
        if (!grant_i) begin
          mem_wdata <= d_wdata;
        end
      end

      if (state == ISSUE) begin
        lat_cnt <= CNT_W'(MEM_LATENCY);
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - CNT_W'(1);
      end

      if (capture) begin
        if (owner == OWN_I) begin
          i_rdata <= mem_rdata;
        end else if (!we_q) begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_en = (state == ISSUE);
  assign mem_we = (state == ISSUE) && we_q;
  assign busy   = (state != IDLE);
  assign i_ack  = (state == RESP) && (owner == OWN_I);
  assign d_ack  = (state == RESP) && (owner == OWN_D);

  a_we_needs_en: assert property (@(posedge clk) disable iff (rst) mem_we |-> mem_en);
  a_ack_onehot:  assert property (@(posedge clk) disable iff (rst) !(i_ack && d_ack));

endmodule
